// File: rtl/isr_arb_pkg.sv
// Shared types and round-robin search helper for the InvertSQRoot arbiter.
package isr_arb_pkg;

   localparam int unsigned FLOAT_W   = 32;
   localparam int unsigned N_REQ_MAX = 8;
   localparam int unsigned ID_W_MAX  = 3;

   typedef struct packed {
      logic                valid;
      logic [ID_W_MAX-1:0] id;
   } isr_tag_t;

   typedef struct packed {
      logic                found;
      logic [ID_W_MAX-1:0] index;
   } rr_pick_t;

   // First asserted bit of vld at or above ptr, wrapping within the low n bits.
   function automatic rr_pick_t rr_pick(input logic [N_REQ_MAX-1:0] vld,
                                        input logic [ID_W_MAX-1:0]  ptr,
                                        input int unsigned          n);
      rr_pick_t            r;
      int unsigned         idx;
      logic [ID_W_MAX-1:0] sel;
      r = '0;
      for (int unsigned k = 0; k < N_REQ_MAX; k++) begin
         idx = (32'(ptr) + k) % n;
         sel = idx[ID_W_MAX-1:0];
         if (k < n && !r.found && vld[sel]) begin
            r.found = 1'b1;
            r.index = sel;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/isr_tag_pipe.sv
// Requester-ID tag pipeline running in lockstep with the InvertSQRoot core.
module isr_tag_pipe
   import isr_arb_pkg::*;
#(
   parameter int unsigned LATENCY = 8,
   parameter int unsigned CNT_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift,
   input  isr_tag_t         in_tag,
   output isr_tag_t         tail_tag,
   output logic [CNT_W-1:0] count
);

   isr_tag_t stage [LATENCY];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < LATENCY; i++) stage[i] <= '0;
         count <= '0;
      end else if (shift) begin
         stage[0] <= in_tag;
         for (int unsigned i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
         count <= count + CNT_W'(in_tag.valid) - CNT_W'(stage[LATENCY-1].valid);
      end
   end

   assign tail_tag = stage[LATENCY-1];

endmodule

// File: rtl/isr_arbiter.sv
// Round-robin sharing of one InvertSQRoot core between N_REQ requesters.
// Optional checker (err_sticky port + one-hot assertion) under ISR_ARB_CHECK_EN.
module isr_arbiter
   import isr_arb_pkg::*;
#(
   parameter  int unsigned N_REQ   = 4,
   parameter  int unsigned LATENCY = 8,
   parameter  int unsigned ID_W    = 2,
   localparam int unsigned CNT_W   = $clog2(LATENCY + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [FLOAT_W*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     res_valid,
   output logic [FLOAT_W-1:0]       res_data,
   output logic [ID_W-1:0]          res_id,
   input  logic                     res_ready,
   output logic                     core_ce,
   output logic [FLOAT_W-1:0]       core_data_in,
   input  logic [FLOAT_W-1:0]       core_data_out,
   input  logic                     core_data_valid,
`ifdef ISR_ARB_CHECK_EN
   output logic                     err_sticky,
`endif
   output logic                     busy,
   output logic [CNT_W-1:0]         inflight
);

   isr_tag_t               tail_tag;
   isr_tag_t               tag_in;
   rr_pick_t               pick;
   logic [ID_W_MAX-1:0]    rr_ptr;
   logic [N_REQ_MAX-1:0]   vld_ext;
   logic                   grant_any;
   logic [ID_W_MAX-1:0]    grant_id;
   logic                   unused_bits;

   // rst gates core_ce so grants and core advance are dead while reset is held.
   always_comb begin
      vld_ext              = '0;
      vld_ext[N_REQ-1:0]   = req_valid;
      core_ce              = en & ~rst & (res_ready | ~tail_tag.valid);
      pick                 = rr_pick(vld_ext, rr_ptr, N_REQ);
      grant_any            = core_ce & pick.found;
      grant_id             = pick.index;
      tag_in.valid         = grant_any;
      tag_in.id            = grant_id;
      req_ready            = '0;
      core_data_in         = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant_any && grant_id == ID_W_MAX'(i)) begin
            req_ready[i] = 1'b1;
            core_data_in = req_data[i*FLOAT_W +: FLOAT_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            rr_ptr <= '0;
      else if (grant_any) rr_ptr <= (grant_id == ID_W_MAX'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
   end

   isr_tag_pipe #(
      .LATENCY (LATENCY),
      .CNT_W   (CNT_W)
   ) u_tag_pipe (
      .clk      (clk),
      .rst      (rst),
      .shift    (core_ce),
      .in_tag   (tag_in),
      .tail_tag (tail_tag),
      .count    (inflight)
   );

   assign res_valid   = tail_tag.valid;
   assign res_data    = core_data_out;
   assign res_id      = tail_tag.id[ID_W-1:0];
   assign busy        = (inflight != '0);
   assign unused_bits = ^{tail_tag, core_data_valid, pick.found};

`ifdef ISR_ARB_CHECK_EN
   // Overflow means a grant with a full pipe that is not draining on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_sticky <= 1'b0;
      else if ((core_ce & tail_tag.valid & ~core_data_valid) |
               (grant_any & (inflight == CNT_W'(LATENCY)) & ~(core_ce & tail_tag.valid)))
         err_sticky <= 1'b1;
   end

   a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
`endif

endmodule

// File: tb/tb_isr_arbiter.sv
// Directed bench for isr_arbiter with a behavioural InvertSQRoot pipeline and result scoreboard.
module tb_isr_arbiter;

   localparam int N = 4;
   localparam int L = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [32*N-1:0] req_data = '0;
   logic [N-1:0]  req_ready;
   logic          res_valid;
   logic [31:0]   res_data;
   logic [1:0]    res_id;
   logic          res_ready = 1'b0;
   logic          core_ce;
   logic [31:0]   core_data_in;
   logic [31:0]   core_data_out;
   logic          core_data_valid;
   logic          busy;
   logic [3:0]    inflight;
`ifdef ISR_ARB_CHECK_EN
   logic          err_sticky;
`endif

   int n_cmp = 0;
   int n_fail = 0;
   int n_consumed = 0;
   int seq [N];
   logic drop_dv = 1'b0;

   typedef struct packed { logic [1:0] id; logic [31:0] data; } exp_t;
   exp_t sb_q [$];

   always #5 clk = ~clk;

   isr_arbiter #(.N_REQ(4), .LATENCY(8), .ID_W(2)) dut (
      .clk(clk), .rst(rst), .en(en),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
      .core_ce(core_ce), .core_data_in(core_data_in),
      .core_data_out(core_data_out), .core_data_valid(core_data_valid),
`ifdef ISR_ARB_CHECK_EN
      .err_sticky(err_sticky),
`endif
      .busy(busy), .inflight(inflight)
   );

   // Reference 1/sqrt(x): exact table for the directed operands, fixed scramble otherwise.
   function automatic logic [31:0] isr_ref(input logic [31:0] x);
      case (x)
         32'h40800000: return 32'h3F000000;
         32'h3F800000: return 32'h3F800000;
         32'h41800000: return 32'h3E800000;
         32'h3E800000: return 32'h40000000;
         default:      return {~x[31:16], x[15:0] ^ 16'h5A5A};
      endcase
   endfunction

   logic [31:0] m_d [L];
   logic        m_v [L];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < L; i++) begin m_d[i] <= '0; m_v[i] <= 1'b0; end
      end else if (core_ce) begin
         m_d[0] <= isr_ref(core_data_in);
         m_v[0] <= 1'b1;
         for (int i = 1; i < L; i++) begin m_d[i] <= m_d[i-1]; m_v[i] <= m_v[i-1]; end
      end
   end
   assign core_data_out   = m_d[L-1];
   assign core_data_valid = m_v[L-1] & ~drop_dv;

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i]) sb_q.push_back({2'(i), isr_ref(req_data[i*32 +: 32])});
         if (en && res_valid && res_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_extra: got id %0d data %h, none expected", res_id, res_data);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               if (res_id !== e.id || res_data !== e.data) begin
                  n_fail++;
                  $display("FAIL sb_result: got id %0d data %h want id %0d data %h", res_id, res_data, e.id, e.data);
               end
            end
            n_consumed++;
         end
      end
   end

   // Call at a negedge: latch handshakes, move past the next posedge, refresh accepted operands.
   task automatic cyc_end();
      logic [N-1:0] hs;
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
         if (hs[i]) begin seq[i]++; req_data[i*32 +: 32] = {4'(i), 28'(seq[i])}; end
   endtask

   task automatic drain();
      req_valid = '0; res_ready = 1'b1; en = 1'b1;
      for (int i = 0; i < L + 4; i++) begin @(negedge clk); cyc_end(); end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; res_ready = 1'b1; req_valid = 4'b1111;
      #23;
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
      n_cmp++; if (core_ce !== 1'b0) begin n_fail++; $display("FAIL rst_core_ce: got %b want 0", core_ce); end
      n_cmp++; if ({res_valid, res_id, busy, inflight} !== '0) begin n_fail++;
         $display("FAIL rst_outputs: got valid %b id %0d busy %b inflight %0d want all 0", res_valid, res_id, busy, inflight); end
      n_cmp++; if (core_data_in !== 32'h0) begin n_fail++; $display("FAIL rst_core_data_in: got %h want 0", core_data_in); end
`ifdef ISR_ARB_CHECK_EN
      n_cmp++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL rst_err_sticky: got %b want 0", err_sticky); end
`endif
      req_valid = '0;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_single();
      int n;
      bit seen;
      int d;
      req_data[31:0] = 32'h40800000; req_valid = 4'b0001;
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", req_ready); end
      n_cmp++; if (core_data_in !== 32'h40800000) begin n_fail++; $display("FAIL single_data_in: got %h want 40800000", core_data_in); end
      @(posedge clk); #1 req_valid = '0; req_data[31:0] = {4'd0, 28'd0};
      n = 0; seen = 0;
      while (!seen && n < 20) begin
         @(negedge clk); n++;
         if (n == 1) begin
            n_cmp++; if (inflight !== 4'd1 || busy !== 1'b1) begin n_fail++;
               $display("FAIL single_inflight: got %0d busy %b want 1 busy 1", inflight, busy); end
         end
         if (res_valid) seen = 1;
      end
      n_cmp++; if (n != 8 || !seen) begin n_fail++; $display("FAIL single_latency: got %0d cycles (seen %0d) want 8", n, seen); end
      n_cmp++; if (res_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d want 0", res_id); end
      d = int'(res_data) - int'(32'h3F000000);
      n_cmp++; if (d < -2 || d > 2) begin n_fail++; $display("FAIL single_value: got %h want 3F000000 +-2ulp", res_data); end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (inflight !== 4'd0 || res_valid !== 1'b0) begin n_fail++;
         $display("FAIL single_drain: got inflight %0d valid %b want 0 0", inflight, res_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin();
      logic [N-1:0] want;
      int pat [4] = '{3, 0, 3, 0};
      // Pointer sits at 1 after the single-requester grant to 0.
      req_valid = 4'b1111; res_ready = 1'b1;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         want = 4'b0001 << ((1 + j) % 4);
         n_cmp++; if (req_ready !== want) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", j, req_ready, want); end
         if (j >= 8) begin
            n_cmp++; if (res_valid !== 1'b1 || res_id !== 2'((1 + j - 8) % 4)) begin n_fail++;
               $display("FAIL rr_result[%0d]: got valid %b id %0d want 1 %0d", j, res_valid, res_id, (1 + j - 8) % 4); end
         end
         cyc_end();
      end
      req_valid = 4'b1001;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         want = 4'b0001 << pat[j];
         n_cmp++; if (req_ready !== want) begin n_fail++; $display("FAIL rr_wrap[%0d]: got %b want %b", j, req_ready, want); end
         cyc_end();
      end
      drain();
   endtask

   task automatic test_backpressure();
      logic [31:0] cap_d;
      logic [1:0]  cap_id;
      int start, budget;
      req_valid = 4'b1111; res_ready = 1'b1;
      for (int j = 0; j < 30; j++) begin @(negedge clk); cyc_end(); end
      res_ready = 1'b0;
      cap_d = '0; cap_id = '0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (j == 0) begin cap_d = res_data; cap_id = res_id; end
         n_cmp++; if (core_ce !== 1'b0 || req_ready !== 4'b0000 || res_valid !== 1'b1 ||
                      res_data !== cap_d || res_id !== cap_id) begin n_fail++;
            $display("FAIL stall_hold[%0d]: got ce %b ready %b valid %b data %h id %0d want 0 0000 1 %h %0d",
                     j, core_ce, req_ready, res_valid, res_data, res_id, cap_d, cap_id); end
         cyc_end();
      end
      start = n_consumed; budget = 0;
      while (n_consumed - start < 1000 && budget < 6000) begin
         res_ready = 1'($urandom_range(0, 3) != 0);
         @(negedge clk); cyc_end(); budget++;
      end
      n_cmp++; if (n_consumed - start < 1000) begin n_fail++;
         $display("FAIL stall_stream: got %0d results want 1000 within budget", n_consumed - start); end
      drain();
   endtask

   task automatic test_enable_toggle();
      int start;
      start = n_consumed;
      req_valid = 4'b1111; res_ready = 1'b1;
      for (int c = 0; c < 240; c++) begin
         en = ((c / 30) % 2) == 0;
         @(negedge clk);
         if (!en) begin
            n_cmp++; if (core_ce !== 1'b0 || req_ready !== 4'b0000) begin n_fail++;
               $display("FAIL en_freeze[%0d]: got ce %b ready %b want 0 0000", c, core_ce, req_ready); end
         end
         cyc_end();
      end
      drain();
      n_cmp++; if (n_consumed - start != 120) begin n_fail++;
         $display("FAIL en_count: got %0d results want 120", n_consumed - start); end
   endtask

   task automatic test_reset_midflight();
      bit bad;
      req_valid = 4'b0100; res_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin @(negedge clk); cyc_end(); end
      req_valid = '0;
      #1;
      n_cmp++; if (inflight !== 4'd5 || busy !== 1'b1) begin n_fail++;
         $display("FAIL mid_inflight: got %0d busy %b want 5 busy 1", inflight, busy); end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (inflight !== 4'd0 || busy !== 1'b0 || res_valid !== 1'b0 || core_ce !== 1'b0 || req_ready !== 4'b0000) begin n_fail++;
         $display("FAIL mid_async_rst: got inflight %0d busy %b valid %b ce %b ready %b want 0 0 0 0 0000",
                  inflight, busy, res_valid, core_ce, req_ready); end
      sb_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      bad = 0;
      for (int j = 0; j < 12; j++) begin @(negedge clk); if (res_valid !== 1'b0) bad = 1; cyc_end(); end
      n_cmp++; if (bad) begin n_fail++; $display("FAIL mid_no_result: got res_valid 1 want 0 after reset"); end
      req_valid = 4'b1111;
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr: got %b want 0001", req_ready); end
      cyc_end();
      drain();
   endtask

`ifdef ISR_ARB_CHECK_EN
   task automatic test_err_sticky();
      int n;
      bit stuck;
      req_valid = 4'b0001; res_ready = 1'b1;
      @(negedge clk); cyc_end();
      req_valid = '0;
      n = 0;
      while (res_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      n_cmp++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b want 0", err_sticky); end
      drop_dv = 1'b1;
      @(posedge clk); #1 drop_dv = 1'b0;
      stuck = 1;
      for (int j = 0; j < 10; j++) begin @(negedge clk); if (err_sticky !== 1'b1) stuck = 0; cyc_end(); end
      n_cmp++; if (!stuck) begin n_fail++; $display("FAIL err_set: got err_sticky %b want held 1", err_sticky); end
      #2 rst = 1'b1; #1;
      n_cmp++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err_sticky); end
      sb_q.delete();
      @(posedge clk); #1 rst = 1'b0;
   endtask
`endif

   task automatic test_final();
      n_cmp++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size()); end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin seq[i] = 0; req_data[i*32 +: 32] = {4'(i), 28'd0}; end
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_enable_toggle();
      test_reset_midflight();
`ifdef ISR_ARB_CHECK_EN
      test_err_sticky();
`endif
      test_final();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
